csr_machine_trap: RTL and testbench
===================================

Name: csr_machine_trap

Overview:
Machine-mode CSR file that owns mstatus, mie, mip, mtvec, mscratch, mepc, mcause and mtval, plus the optional cycle/instret counters. It receives the trap-entry and mret update strobes from the CPU control block and the software CSR-instruction read/write port. It returns to the control block the live interrupt-enable, interrupt-pending, trap-vector and restore-PC fields that control uses for trap detection and PC redirection.

Parameters:
PC_WIDTH, 32, width of mepc and PC values
WORD_WIDTH, 32, CSR data width
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (base and mode)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csr_rd_addr  in  12  software read address
csr_rd_data  out  WORD_WIDTH  combinational read data
csr_rd_valid  out  1  1 when csr_rd_addr is an implemented CSR
csr_wr_en  in  1  software write strobe, already qualified by stall/flush
csr_wr_addr  in  12  software write address
csr_wr_data  in  WORD_WIDTH  software write data
mstatus_mie_clear_en  in  1  trap entry
mstatus_mie_set_en  in  1  mret
mepc_set_en  in  1  load mepc
mepc_set_pc  in  PC_WIDTH  trap PC
mcause_set_en  in  1  load mcause
mcause_set_cause  in  WORD_WIDTH  {interrupt, code[30:0]}
mtval_set_en  in  1  load mtval
mtval_set_tval  in  WORD_WIDTH  trap value
irq_external  in  1  external interrupt line, level
irq_timer  in  1  timer interrupt line, level
irq_software  in  1  software interrupt line, level
instret  in  1  one pulse per retired instruction
csr_mstatus_mpie, csr_mstatus_mie  out  1 each  mstatus bits 7 and 3
csr_mie_meie, csr_mie_mtie, csr_mie_msie  out  1 each  mie bits 11, 7 and 3
csr_mip_meip, csr_mip_mtip, csr_mip_msip  out  1 each  mip bits 11, 7 and 3
csr_mtvec_base  out  30  mtvec[31:2]
csr_mtvec_mode  out  2  mtvec[1:0]
csr_mepc_pc  out  PC_WIDTH  mepc

Behaviour:
- All state is registered. Every field output is driven directly from a register, so a write becomes visible on outputs and reads one cycle after its strobe.
- Reset values: mstatus MIE=0 and MPIE=0; mie=0; mip=0; mtvec=MTVEC_RESET; mscratch, mepc, mcause and mtval are 0; counters are 0.
- Address map:
  - mstatus 0x300; misa 0x301 (read-only constant 0x4000_0100, RV32I); mie 0x304; mtvec 0x305.
  - mscratch 0x340; mepc 0x341; mcause 0x342; mtval 0x343; mip 0x344.
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - Unimplemented address: csr_rd_data=0, csr_rd_valid=0, and writes are ignored.
- WARL rules:
  - mstatus: only bits 3 and 7 are writable; bits 12:11 (MPP) always read 2'b11; all other bits read 0.
  - mie: only bits 11, 7 and 3 are writable.
  - mtvec: bit1 is forced to 0, so mode is 0 or 1.
  - mepc: bits 1:0 are forced to 0 on both software and trap writes.
- mip is read-only. Bits 11, 7 and 3 register irq_external, irq_timer and irq_software each cycle (1-cycle latency). Software writes to mip are ignored.
- Trap entry (mstatus_mie_clear_en): MPIE <= MIE, MIE <= 0.
- mret (mstatus_mie_set_en): MIE <= MPIE, MPIE <= 1.
- clear_en and set_en both asserted in the same cycle: clear_en wins.
- Priority per register: hardware strobes (trap/mret/mepc/mcause/mtval set) override a software write to the same register in the same cycle. Software writes to other registers in that cycle still take effect.
- Counters:
  - 64-bit. mcycle increments every cycle; minstret increments on instret.
  - Carry propagates from the low half to the high half; 2^64-1 wraps to 0.
  - A software write to either half replaces that half and suppresses the increment for that cycle only. The other half holds its value, with no carry that cycle.
- Reset asserted mid-operation returns all state to reset values on the next edge, regardless of any strobes.

Optional Feature:
CSR_COUNTERS_EN:
- Defined: mcycle/mcycleh and minstret/minstreth are implemented as above.
- Undefined: the counters are not instantiated; their addresses read 0 with csr_rd_valid=1, writes are ignored, and the instret input is unused.

Test Plan:
- Reset, then read all addresses -> every output at its reset value; misa=0x4000_0100; mstatus=0x0000_1800; 0x7C0 gives rd_valid=0, data=0.
- Write mstatus=0x0000_0008, then pulse mstatus_mie_clear_en with mepc_set_pc=0x0000_0103 and mcause_set_cause=0x8000_000B -> next cycle MIE=0, MPIE=1, mepc=0x0000_0100, mcause=0x8000_000B.
- Pulse mstatus_mie_set_en after the previous case -> MIE=1, MPIE=1; csr_mepc_pc unchanged.
- Same cycle: software write mepc=0x0000_2000 and mepc_set_en with mepc_set_pc=0x0000_3000 -> mepc=0x0000_3000.
- irq_timer high for one cycle -> csr_mip_mtip high exactly one cycle later for one cycle; a write of mip=0xFFFF_FFFF has no effect.
- With CSR_COUNTERS_EN defined, write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF -> two cycles later {mcycleh, mcycle}=0x0000_0000_0000_0000. Separately, mcycle=0xFFFF_FFFF with mcycleh=5 -> mcycleh=6 next cycle.

Source files
------------

// File: rtl/csr_machine_trap.sv
// Machine-mode CSR file: trap/mret status updates, interrupt enable/pending, trap vector and restore PC.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_machine_trap #(
   parameter int          PC_WIDTH    = 32,
   parameter int          WORD_WIDTH  = 32,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [11:0]           csr_rd_addr,
   output logic [WORD_WIDTH-1:0] csr_rd_data,
   output logic                  csr_rd_valid,
   input  logic                  csr_wr_en,
   input  logic [11:0]           csr_wr_addr,
   input  logic [WORD_WIDTH-1:0] csr_wr_data,
   input  logic                  mstatus_mie_clear_en,
   input  logic                  mstatus_mie_set_en,
   input  logic                  mepc_set_en,
   input  logic [PC_WIDTH-1:0]   mepc_set_pc,
   input  logic                  mcause_set_en,
   input  logic [WORD_WIDTH-1:0] mcause_set_cause,
   input  logic                  mtval_set_en,
   input  logic [WORD_WIDTH-1:0] mtval_set_tval,
   input  logic                  irq_external,
   input  logic                  irq_timer,
   input  logic                  irq_software,
   input  logic                  instret,
   output logic                  csr_mstatus_mpie,
   output logic                  csr_mstatus_mie,
   output logic                  csr_mie_meie,
   output logic                  csr_mie_mtie,
   output logic                  csr_mie_msie,
   output logic                  csr_mip_meip,
   output logic                  csr_mip_mtip,
   output logic                  csr_mip_msip,
   output logic [29:0]           csr_mtvec_base,
   output logic [1:0]            csr_mtvec_mode,
   output logic [PC_WIDTH-1:0]   csr_mepc_pc
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MISA     = 12'h301;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MTVAL    = 12'h343;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRH  = 12'hB82;

   localparam logic [31:0]         MISA_VALUE  = 32'h4000_0100;
   localparam logic [31:0]         MTVEC_MASK  = 32'hFFFF_FFFD;
   localparam logic [PC_WIDTH-1:0] MEPC_MASK   = {{(PC_WIDTH-2){1'b1}}, 2'b00};

   logic [31:0]           mtvec;
   logic [WORD_WIDTH-1:0] mscratch;
   logic [WORD_WIDTH-1:0] mcause;
   logic [WORD_WIDTH-1:0] mtval;
   logic [PC_WIDTH-1:0]   mepc;
   logic [63:0]           mcycle;
   logic [63:0]           minstret;

   logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;

   assign wr_mstatus  = csr_wr_en && (csr_wr_addr == ADDR_MSTATUS);
   assign wr_mie      = csr_wr_en && (csr_wr_addr == ADDR_MIE);
   assign wr_mtvec    = csr_wr_en && (csr_wr_addr == ADDR_MTVEC);
   assign wr_mscratch = csr_wr_en && (csr_wr_addr == ADDR_MSCRATCH);
   assign wr_mepc     = csr_wr_en && (csr_wr_addr == ADDR_MEPC);
   assign wr_mcause   = csr_wr_en && (csr_wr_addr == ADDR_MCAUSE);
   assign wr_mtval    = csr_wr_en && (csr_wr_addr == ADDR_MTVAL);

   // Hardware strobes sit ahead of the software write in every chain below.
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_mstatus_mie  <= 1'b0;
         csr_mstatus_mpie <= 1'b0;
         csr_mie_meie     <= 1'b0;
         csr_mie_mtie     <= 1'b0;
         csr_mie_msie     <= 1'b0;
         csr_mip_meip     <= 1'b0;
         csr_mip_mtip     <= 1'b0;
         csr_mip_msip     <= 1'b0;
         mtvec            <= MTVEC_RESET & MTVEC_MASK;
         mscratch         <= '0;
         mepc             <= '0;
         mcause           <= '0;
         mtval            <= '0;
      end else begin
         if (mstatus_mie_clear_en) begin
            csr_mstatus_mpie <= csr_mstatus_mie;
            csr_mstatus_mie  <= 1'b0;
         end else if (mstatus_mie_set_en) begin
            csr_mstatus_mie  <= csr_mstatus_mpie;
            csr_mstatus_mpie <= 1'b1;
         end else if (wr_mstatus) begin
            csr_mstatus_mie  <= csr_wr_data[3];
            csr_mstatus_mpie <= csr_wr_data[7];
         end

         if (wr_mie) begin
            csr_mie_meie <= csr_wr_data[11];
            csr_mie_mtie <= csr_wr_data[7];
            csr_mie_msie <= csr_wr_data[3];
         end

         csr_mip_meip <= irq_external;
         csr_mip_mtip <= irq_timer;
         csr_mip_msip <= irq_software;

         if (wr_mtvec)    mtvec    <= csr_wr_data[31:0] & MTVEC_MASK;
         if (wr_mscratch) mscratch <= csr_wr_data;

         if (mepc_set_en)  mepc <= mepc_set_pc & MEPC_MASK;
         else if (wr_mepc) mepc <= PC_WIDTH'(csr_wr_data) & MEPC_MASK;

         if (mcause_set_en)  mcause <= mcause_set_cause;
         else if (wr_mcause) mcause <= csr_wr_data;

         if (mtval_set_en)  mtval <= mtval_set_tval;
         else if (wr_mtval) mtval <= csr_wr_data;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

   assign wr_mcycle    = csr_wr_en && (csr_wr_addr == ADDR_MCYCLE);
   assign wr_mcycleh   = csr_wr_en && (csr_wr_addr == ADDR_MCYCLEH);
   assign wr_minstret  = csr_wr_en && (csr_wr_addr == ADDR_MINSTRET);
   assign wr_minstreth = csr_wr_en && (csr_wr_addr == ADDR_MINSTRH);

   // A write to one half freezes the whole counter for that cycle, so no carry leaks across.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (wr_mcycle)       mcycle[31:0]  <= csr_wr_data[31:0];
         else if (wr_mcycleh) mcycle[63:32] <= csr_wr_data[31:0];
         else                 mcycle        <= mcycle + 64'd1;

         if (wr_minstret)       minstret[31:0]  <= csr_wr_data[31:0];
         else if (wr_minstreth) minstret[63:32] <= csr_wr_data[31:0];
         else if (instret)      minstret        <= minstret + 64'd1;
      end
   end
`else
   logic unused_instret;

   assign unused_instret = instret;
   assign mcycle         = '0;
   assign minstret       = '0;
`endif

   always_comb begin
      csr_rd_data  = '0;
      csr_rd_valid = 1'b1;
      case (csr_rd_addr)
         ADDR_MSTATUS:  csr_rd_data = WORD_WIDTH'({19'd0, 2'b11, 3'd0, csr_mstatus_mpie,
                                                   3'd0, csr_mstatus_mie, 3'd0});
         ADDR_MISA:     csr_rd_data = WORD_WIDTH'(MISA_VALUE);
         ADDR_MIE:      csr_rd_data = WORD_WIDTH'({20'd0, csr_mie_meie, 3'd0, csr_mie_mtie,
                                                   3'd0, csr_mie_msie, 3'd0});
         ADDR_MTVEC:    csr_rd_data = WORD_WIDTH'(mtvec);
         ADDR_MSCRATCH: csr_rd_data = mscratch;
         ADDR_MEPC:     csr_rd_data = WORD_WIDTH'(mepc);
         ADDR_MCAUSE:   csr_rd_data = mcause;
         ADDR_MTVAL:    csr_rd_data = mtval;
         ADDR_MIP:      csr_rd_data = WORD_WIDTH'({20'd0, csr_mip_meip, 3'd0, csr_mip_mtip,
                                                   3'd0, csr_mip_msip, 3'd0});
         ADDR_MCYCLE:   csr_rd_data = WORD_WIDTH'(mcycle[31:0]);
         ADDR_MCYCLEH:  csr_rd_data = WORD_WIDTH'(mcycle[63:32]);
         ADDR_MINSTRET: csr_rd_data = WORD_WIDTH'(minstret[31:0]);
         ADDR_MINSTRH:  csr_rd_data = WORD_WIDTH'(minstret[63:32]);
         default: begin
            csr_rd_data  = '0;
            csr_rd_valid = 1'b0;
         end
      endcase
   end

   assign csr_mtvec_base = mtvec[31:2];
   assign csr_mtvec_mode = mtvec[1:0];
   assign csr_mepc_pc    = mepc;

endmodule

// File: tb/tb_csr_machine_trap.sv
// Bench for csr_machine_trap: directed trap/mret/irq/counter steps, then random traffic
// checked against a word-level model of the CSR file.
module tb_csr_machine_trap;

  localparam logic [31:0] MTVEC_RST = 32'h8000_0003;

  logic        clk;
  logic        rst;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_valid;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        mstatus_mie_clear_en, mstatus_mie_set_en;
  logic        mepc_set_en, mcause_set_en, mtval_set_en;
  logic [31:0] mepc_set_pc, mcause_set_cause, mtval_set_tval;
  logic        irq_external, irq_timer, irq_software, instret;
  logic        csr_mstatus_mpie, csr_mstatus_mie;
  logic        csr_mie_meie, csr_mie_mtie, csr_mie_msie;
  logic        csr_mip_meip, csr_mip_mtip, csr_mip_msip;
  logic [29:0] csr_mtvec_base;
  logic [1:0]  csr_mtvec_mode;
  logic [31:0] csr_mepc_pc;

  csr_machine_trap #(.PC_WIDTH(32), .WORD_WIDTH(32), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst),
    .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_rd_valid(csr_rd_valid),
    .csr_wr_en(csr_wr_en), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
    .mstatus_mie_clear_en(mstatus_mie_clear_en), .mstatus_mie_set_en(mstatus_mie_set_en),
    .mepc_set_en(mepc_set_en), .mepc_set_pc(mepc_set_pc),
    .mcause_set_en(mcause_set_en), .mcause_set_cause(mcause_set_cause),
    .mtval_set_en(mtval_set_en), .mtval_set_tval(mtval_set_tval),
    .irq_external(irq_external), .irq_timer(irq_timer), .irq_software(irq_software),
    .instret(instret),
    .csr_mstatus_mpie(csr_mstatus_mpie), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mie_meie(csr_mie_meie), .csr_mie_mtie(csr_mie_mtie), .csr_mie_msie(csr_mie_msie),
    .csr_mip_meip(csr_mip_meip), .csr_mip_mtip(csr_mip_mtip), .csr_mip_msip(csr_mip_msip),
    .csr_mtvec_base(csr_mtvec_base), .csr_mtvec_mode(csr_mtvec_mode),
    .csr_mepc_pc(csr_mepc_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model: architectural register values as read by software
  logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_tab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                 12'hB82, 12'h7C0, 12'h306, 12'hF14};

  function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic wr_lo,
                                           input logic wr_hi, input logic inc,
                                           input logic [31:0] d);
    if (wr_lo)      return {cur[63:32], d};
    else if (wr_hi) return {d, cur[31:0]};
    else if (inc)   return cur + 64'd1;
    else            return cur;
  endfunction

  // Applies the inputs currently driven, as the next clock edge will.
  task automatic model_step();
    logic        wr;
    logic [11:0] a;
    logic [31:0] d, ns;
    if (rst) begin
      m_mstatus = 32'h0000_1800; m_mie = 0; m_mip = 0; m_mtvec = MTVEC_RST & ~32'h2;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
      return;
    end
    wr = csr_wr_en; a = csr_wr_addr; d = csr_wr_data;
    ns = m_mstatus;
    if (mstatus_mie_clear_en)           ns = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
    else if (mstatus_mie_set_en)        ns = 32'h1880 | (m_mstatus[7] ? 32'h08 : 32'h0);
    else if (wr && a == 12'h300)        ns = 32'h1800 | (d & 32'h88);
    m_mstatus = ns;
    if (wr && a == 12'h304) m_mie = d & 32'h888;
    if (wr && a == 12'h305) m_mtvec = d & ~32'h2;
    if (wr && a == 12'h340) m_mscratch = d;
    if (mepc_set_en)                    m_mepc = mepc_set_pc & ~32'h3;
    else if (wr && a == 12'h341)        m_mepc = d & ~32'h3;
    if (mcause_set_en)                  m_mcause = mcause_set_cause;
    else if (wr && a == 12'h342)        m_mcause = d;
    if (mtval_set_en)                   m_mtval = mtval_set_tval;
    else if (wr && a == 12'h343)        m_mtval = d;
    m_mip = (irq_external ? 32'h800 : 0) | (irq_timer ? 32'h80 : 0) | (irq_software ? 32'h8 : 0);
`ifdef CSR_COUNTERS_EN
    m_cycle   = cnt_next(m_cycle, wr && a == 12'hB00, wr && a == 12'hB80, 1'b1, d);
    m_instret = cnt_next(m_instret, wr && a == 12'hB02, wr && a == 12'hB82, instret, d);
`endif
  endtask

  function automatic void exp_rd(input logic [11:0] a, output logic v, output logic [31:0] d);
    v = 1'b1;
    d = 32'h0;
    case (a)
      12'h300: d = m_mstatus;
      12'h301: d = 32'h4000_0100;
      12'h304: d = m_mie;
      12'h305: d = m_mtvec;
      12'h340: d = m_mscratch;
      12'h341: d = m_mepc;
      12'h342: d = m_mcause;
      12'h343: d = m_mtval;
      12'h344: d = m_mip;
      12'hB00: d = m_cycle[31:0];
      12'hB80: d = m_cycle[63:32];
      12'hB02: d = m_instret[31:0];
      12'hB82: d = m_instret[63:32];
      default: v = 1'b0;
    endcase
  endfunction

  // scoreboard helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_read(input logic [11:0] a);
    logic        v;
    logic [31:0] d;
    csr_rd_addr = a;
    #1;
    exp_rd(a, v, d);
    chk($sformatf("rd_valid@%h", a), 64'(csr_rd_valid), 64'(v));
    chk($sformatf("rd_data@%h", a), 64'(csr_rd_data), 64'(d));
  endtask

  task automatic chk_fields();
    chk("mstatus_mie",  64'(csr_mstatus_mie),  64'(m_mstatus[3]));
    chk("mstatus_mpie", 64'(csr_mstatus_mpie), 64'(m_mstatus[7]));
    chk("mie_bits", 64'({csr_mie_meie, csr_mie_mtie, csr_mie_msie}),
        64'({m_mie[11], m_mie[7], m_mie[3]}));
    chk("mip_bits", 64'({csr_mip_meip, csr_mip_mtip, csr_mip_msip}),
        64'({m_mip[11], m_mip[7], m_mip[3]}));
    chk("mtvec_base", 64'(csr_mtvec_base), 64'(m_mtvec[31:2]));
    chk("mtvec_mode", 64'(csr_mtvec_mode), 64'(m_mtvec[1:0]));
    chk("mepc_pc",    64'(csr_mepc_pc),    64'(m_mepc));
  endtask

  // driver tasks
  task automatic idle();
    csr_wr_en = 0; csr_wr_addr = 0; csr_wr_data = 0;
    mstatus_mie_clear_en = 0; mstatus_mie_set_en = 0;
    mepc_set_en = 0; mepc_set_pc = 0; mcause_set_en = 0; mcause_set_cause = 0;
    mtval_set_en = 0; mtval_set_tval = 0; instret = 0;
  endtask

  task automatic sw_write(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en = 1; csr_wr_addr = a; csr_wr_data = d;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd_tmp;

  initial begin
    rst = 1; csr_rd_addr = 0; irq_external = 0; irq_timer = 0; irq_software = 0;
    idle();
    #2;
    step();
    step();

    // reset state
    chk_fields();
    foreach (addr_tab[i]) chk_read(addr_tab[i]);
    csr_rd_addr = 12'h300; #1; chk("mstatus_reset_word", 64'(csr_rd_data), 64'h1800);
    csr_rd_addr = 12'h301; #1; chk("misa_const", 64'(csr_rd_data), 64'h4000_0100);
    csr_rd_addr = 12'h7C0; #1; chk("unimpl_valid", 64'(csr_rd_valid), 64'h0);
    chk("mtvec_reset_mode", 64'(csr_mtvec_mode), 64'h1);
    chk("mtvec_reset_base", 64'(csr_mtvec_base), 64'(30'h2000_0000));
    rst = 0;

    // trap entry with MIE set
    sw_write(12'h300, 32'h0000_0008);
    step(); idle();
    chk("mie_after_write", 64'(csr_mstatus_mie), 64'h1);
    mstatus_mie_clear_en = 1; mepc_set_en = 1; mepc_set_pc = 32'h0000_0103;
    mcause_set_en = 1; mcause_set_cause = 32'h8000_000B;
    step(); idle();
    chk("trap_mie", 64'(csr_mstatus_mie), 64'h0);
    chk("trap_mpie", 64'(csr_mstatus_mpie), 64'h1);
    chk("trap_mepc", 64'(csr_mepc_pc), 64'h0000_0100);
    csr_rd_addr = 12'h342; #1; chk("trap_mcause", 64'(csr_rd_data), 64'h8000_000B);
    chk_fields();

    // mret
    mstatus_mie_set_en = 1;
    step(); idle();
    chk("mret_mie", 64'(csr_mstatus_mie), 64'h1);
    chk("mret_mpie", 64'(csr_mstatus_mpie), 64'h1);
    chk("mret_mepc", 64'(csr_mepc_pc), 64'h0000_0100);

    // hardware mepc load beats software write
    sw_write(12'h341, 32'h0000_2000); mepc_set_en = 1; mepc_set_pc = 32'h0000_3000;
    step(); idle();
    chk("mepc_hw_wins", 64'(csr_mepc_pc), 64'h0000_3000);

    // clear and set together: clear wins
    mstatus_mie_clear_en = 1; mstatus_mie_set_en = 1;
    step(); idle();
    chk("clr_set_mie", 64'(csr_mstatus_mie), 64'h0);
    chk("clr_set_mpie", 64'(csr_mstatus_mpie), 64'h1);

    // timer irq pulse; mip write ignored
    irq_timer = 1; sw_write(12'h344, 32'hFFFF_FFFF);
    step(); idle(); irq_timer = 0;
    chk("mtip_high", 64'(csr_mip_mtip), 64'h1);
    csr_rd_addr = 12'h344; #1; chk("mip_word", 64'(csr_rd_data), 64'h80);
    sw_write(12'h344, 32'hFFFF_FFFF);
    step(); idle();
    chk("mtip_low", 64'(csr_mip_mtip), 64'h0);
    chk_fields();

`ifdef CSR_COUNTERS_EN
    sw_write(12'hB00, 32'hFFFF_FFFF); step();
    sw_write(12'hB80, 32'hFFFF_FFFF); step(); idle();
    step();
    csr_rd_addr = 12'hB00; #1; chk("mcycle_wrap_lo", 64'(csr_rd_data), 64'h0);
    csr_rd_addr = 12'hB80; #1; chk("mcycle_wrap_hi", 64'(csr_rd_data), 64'h0);
    sw_write(12'hB80, 32'h5); step();
    sw_write(12'hB00, 32'hFFFF_FFFF); step(); idle();
    csr_rd_addr = 12'hB80; #1; chk("mcycleh_hold", 64'(csr_rd_data), 64'h5);
    step();
    csr_rd_addr = 12'hB80; #1; chk("mcycleh_carry", 64'(csr_rd_data), 64'h6);
    csr_rd_addr = 12'hB00; #1; chk("mcycle_carry_lo", 64'(csr_rd_data), 64'h0);
`else
    sw_write(12'hB00, 32'h1234_5678); step(); idle();
    csr_rd_addr = 12'hB00; #1; chk("mcycle_absent", 64'(csr_rd_data), 64'h0);
    chk("mcycle_absent_valid", 64'(csr_rd_valid), 64'h1);
`endif
    foreach (addr_tab[i]) chk_read(addr_tab[i]);

    // random traffic, with occasional reset under active strobes
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) begin
        rd_tmp = $urandom;
        sw_write(addr_tab[$urandom_range(0, 15)], rd_tmp);
      end
      mstatus_mie_clear_en = ($urandom_range(0, 5) == 0);
      mstatus_mie_set_en   = ($urandom_range(0, 5) == 0);
      mepc_set_en          = ($urandom_range(0, 4) == 0);
      mepc_set_pc          = $urandom;
      mcause_set_en        = ($urandom_range(0, 4) == 0);
      mcause_set_cause     = $urandom;
      mtval_set_en         = ($urandom_range(0, 4) == 0);
      mtval_set_tval       = $urandom;
      irq_external         = 1'($urandom_range(0, 1));
      irq_timer            = 1'($urandom_range(0, 1));
      irq_software         = 1'($urandom_range(0, 1));
      instret              = 1'($urandom_range(0, 1));
      step();
      chk_fields();
      chk_read(addr_tab[$urandom_range(0, 15)]);
    end
    rst = 0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
